// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR-feedback LFSR generator and checker.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 10;
  localparam int LFSR_X1    = 6;
  localparam int LFSR_X2    = 9;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the serial XNOR LFSR stream: fills from the
// line in SEARCH, then flywheels on its own prediction in LOCKED.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH       = LFSR_WIDTH,
  parameter int X1          = LFSR_X1,
  parameter int X2          = LFSR_X2,
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck,
  output logic [WIDTH-1:0] q
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int CNT_W  = $clog2(max_int(LOCK_COUNT, LOSS_THRESH) + 1);

  chk_state_t        state, state_next;
  logic [FILL_W-1:0] fill_count;
  logic [CNT_W-1:0]  match_count, miss_count;
  logic [WIDTH-1:0]  q_next;
  logic              p, mis, full, full_next, ones_next;
  logic              acc_search, acc_locked;
  logic              s_cmp, s_stuck, match_inc, lock_go;
  logic              l_mis, l_stuck, loss_go, leave_locked;

  assign p          = ~(q[X1] ^ q[X2]);
  assign mis        = (in != p);
  assign acc_search = in_valid && (state == SEARCH);
  assign acc_locked = in_valid && (state == LOCKED);

  // In LOCKED the register is fed the prediction so line errors never enter it.
  assign q_next    = {q[WIDTH-2:0], (state == LOCKED) ? p : in};
  assign ones_next = &q_next;
  assign full      = (fill_count == FILL_W'(WIDTH));
  assign full_next = full || (fill_count == FILL_W'(WIDTH - 1));

  assign s_cmp     = acc_search && full;
  assign s_stuck   = acc_search && full_next && ones_next;
  assign match_inc = s_cmp && !mis && !ones_next;
  assign lock_go   = match_inc && (match_count >= CNT_W'(LOCK_COUNT - 1));

  assign l_mis        = acc_locked && mis;
  assign l_stuck      = acc_locked && ones_next;
  assign loss_go      = l_mis && (miss_count >= CNT_W'(LOSS_THRESH - 1));
  assign leave_locked = l_stuck || loss_go;

  sat_counter #(.W(FILL_W)) u_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (acc_search && !full),
    .clr     (leave_locked),
    .count   (fill_count)
  );

  sat_counter #(.W(CNT_W)) u_match (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (match_inc),
    .clr     ((s_cmp && mis) || s_stuck || lock_go || leave_locked),
    .count   (match_count)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (l_mis),
    .clr     ((acc_locked && !mis) || leave_locked),
    .count   (miss_count)
  );

  sat_counter #(.W(ERR_W)) u_err (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (l_mis),
    .clr     (1'b0),
    .count   (err_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (lock_go)      state_next = LOCKED;
      LOCKED:  if (leave_locked) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q       <= '0;
      bit_err <= 1'b0;
      stuck   <= 1'b0;
    end else begin
      if (in_valid) q <= q_next;
      bit_err <= l_mis;
      if (s_stuck || l_stuck) stuck <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: loopback generator stimulus, queue-based reference
// model compared every cycle, plus directed literal checks.
module tb_lfsr_checker;

  localparam int W     = 10;
  localparam int X1    = 6;
  localparam int X2    = 9;
  localparam int LOCK  = 16;
  localparam int LOSS  = 4;
  localparam int EW    = 16;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in;
  logic          locked;
  logic          bit_err;
  logic [EW-1:0] err_count;
  logic          stuck;
  logic [W-1:0]  q;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  lfsr_checker #(
    .WIDTH(W), .X1(X1), .X2(X2), .LOCK_COUNT(LOCK), .LOSS_THRESH(LOSS), .ERR_W(EW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in        (in),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_count (err_count),
    .stuck     (stuck),
    .q         (q)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: m_ref holds the last W reference bits, newest at the back
  bit m_ref[$];
  int m_fill, m_match, m_miss, m_err;
  bit m_locked, m_stuck, m_bit_err;

  function automatic bit m_all_ones();
    foreach (m_ref[k]) if (!m_ref[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_ref.delete();
    repeat (W) m_ref.push_back(1'b0);
    m_fill = 0; m_match = 0; m_miss = 0; m_err = 0;
    m_locked = 0; m_stuck = 0; m_bit_err = 0;
  endtask

  always @(posedge clk) begin : model
    bit pred, pre_full, all1, mis;
    if (!reset_n) begin
      model_reset();
    end else if (in_valid) begin
      pred = ~(m_ref[W-1-X1] ^ m_ref[W-1-X2]);
      m_bit_err = 1'b0;
      if (!m_locked) begin
        pre_full = (m_fill == W);
        m_ref.push_back(in);
        void'(m_ref.pop_front());
        if (m_fill < W) m_fill++;
        all1 = m_all_ones();
        if (m_fill == W && all1) begin
          m_stuck = 1'b1;
          m_match = 0;
        end else if (pre_full) begin
          m_match = (in == pred) ? m_match + 1 : 0;
        end
        if (m_match == LOCK) begin
          m_locked = 1'b1;
          m_match = 0;
          m_miss = 0;
        end
      end else begin
        m_ref.push_back(pred);
        void'(m_ref.pop_front());
        mis = (in != pred);
        if (mis) begin
          m_bit_err = 1'b1;
          if (m_err < EMAX) m_err++;
          m_miss++;
        end else begin
          m_miss = 0;
        end
        all1 = m_all_ones();
        if (all1 || m_miss == LOSS) begin
          if (all1) m_stuck = 1'b1;
          m_locked = 1'b0;
          m_fill = 0; m_match = 0; m_miss = 0;
        end
      end
    end else begin
      m_bit_err = 1'b0;
    end
  end

  // scoreboard: every cycle after the first reset
  always @(negedge clk) begin : compare
    logic [W-1:0] mq;
    if (chk_en) begin
      for (int k = 0; k < W; k++) mq[k] = m_ref[W-1-k];
      check("model_locked", locked, m_locked);
      check("model_bit_err", bit_err, m_bit_err);
      check("model_err_count", err_count, m_err);
      check("model_stuck", stuck, m_stuck);
      check("model_q", q, mq);
    end
  end

  // driver tasks
  logic [W-1:0] gen_q;

  task automatic gen_next(output logic b);
    b = ~(gen_q[X1] ^ gen_q[X2]);
    gen_q = {gen_q[W-2:0], b};
  endtask

  task automatic send_bit(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 1'b1;
    in = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int lock_idx, unlock_idx, relock_idx, pulses, first_pulse, accepted;
  logic [W-1:0] q_at_10;
  logic locked_at_25;

  task automatic run_gen(input int n_cyc, input int inv_lo, input int inv_hi,
                         input bit rand_valid, input bit fresh);
    logic v, b, prev;
    int idx;
    if (fresh) begin
      do_reset();
      gen_q = 10'b0101010101;
    end
    idx = 0; prev = locked;
    lock_idx = -1; unlock_idx = -1; relock_idx = -1;
    pulses = 0; first_pulse = -1; q_at_10 = 'x; locked_at_25 = 1'bx;
    for (int c = 0; c < n_cyc; c++) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        gen_next(b);
        idx++;
        if (idx >= inv_lo && idx <= inv_hi) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      send_bit(v, b);
      if (v) begin
        if (idx == 10) q_at_10 = q;
        if (idx == 25) locked_at_25 = locked;
        if (bit_err) begin
          pulses++;
          if (first_pulse < 0) first_pulse = idx;
        end
        if (locked && !prev) begin
          if (lock_idx < 0) lock_idx = idx;
          else relock_idx = idx;
        end
        if (!locked && prev) unlock_idx = idx;
        prev = locked;
      end
    end
    accepted = idx;
  endtask

  initial begin : stimulus
    bit ever_locked;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in = 1'b0;
    do_reset();
    chk_en = 1'b1;
    check("reset_locked", locked, 0);
    check("reset_err_count", err_count, 0);
    check("reset_stuck", stuck, 0);
    check("reset_q", q, 0);

    // clean loopback
    run_gen(300, 0, -1, 1'b0, 1'b1);
    check("clean_q_after_10", q_at_10, 10'h002);
    check("clean_unlocked_at_25", locked_at_25, 0);
    check("clean_lock_idx", lock_idx, 26);
    check("clean_pulses", pulses, 0);
    check("clean_err_count", err_count, 0);
    check("clean_stuck", stuck, 0);

    // single inverted bit at index 150
    run_gen(300, 150, 150, 1'b0, 1'b1);
    check("single_pulses", pulses, 1);
    check("single_pulse_idx", first_pulse, 150);
    check("single_err_count", err_count, 1);
    check("single_no_unlock", unlock_idx, -1);
    check("single_locked_end", locked, 1);

    // four consecutive errors force loss of lock, then relock
    run_gen(300, 200, 203, 1'b0, 1'b1);
    check("burst_pulses", pulses, 4);
    check("burst_first_pulse", first_pulse, 200);
    check("burst_unlock_idx", unlock_idx, 203);
    check("burst_relock_idx", relock_idx, 229);
    check("burst_err_count", err_count, 4);
    check("burst_locked_end", locked, 1);

    // gapped stream: lock counted in accepted bits only
    run_gen(600, 0, -1, 1'b1, 1'b1);
    check("gapped_lock_idx", lock_idx, 26);
    check("gapped_pulses", pulses, 0);
    check("gapped_err_count", err_count, 0);

    // constant ones: lockup
    do_reset();
    ever_locked = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      send_bit(1'b1, 1'b1);
      if (i == 9) check("ones_stuck_before_10", stuck, 0);
      if (i == 10) check("ones_stuck_at_10", stuck, 1);
      if (locked) ever_locked = 1'b1;
    end
    check("ones_never_locked", ever_locked, 0);
    check("ones_err_count", err_count, 0);
    check("ones_stuck_end", stuck, 1);

    // reset mid-lock
    run_gen(30, 28, 28, 1'b0, 1'b1);
    check("midrst_locked_before", locked, 1);
    check("midrst_err_before", err_count, 1);
    do_reset();
    check("midrst_locked", locked, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_stuck", stuck, 0);
    check("midrst_q", q, 0);
    run_gen(40, 0, -1, 1'b0, 1'b0);
    check("midrst_relock_idx", lock_idx, 26);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's 10-bit XNOR-feedback LFSR pattern generator.
- Consumes the serial pseudo-random bit stream, self-synchronises to it, then checks every later bit against the predicted sequence.
- Reports lock status, per-bit error pulses, a saturating error count and all-ones lockup.
- Used as a link/self-test sink for serial paths driven by the generator.

Parameters:
- WIDTH, 10, shift-register length; equals the generator's.
- X1, 6, first feedback tap index.
- X2, 9, second feedback tap index.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock (full register needed first).
- LOSS_THRESH, 4, consecutive mispredictions in LOCKED that force return to SEARCH.
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in carries a stream bit this cycle.
- in  input  1  serial stream bit.
- locked  output  1  high while in LOCKED.
- bit_err  output  1  one-cycle pulse: last accepted bit mismatched the prediction while LOCKED.
- err_count  output  ERR_W  saturating total of mismatches counted in LOCKED.
- stuck  output  1  sticky all-ones lockup detected; cleared only by reset.
- q  output  WIDTH  internal reference register, for debug.

Behaviour:
- Reset: a clock edge with reset_n=0 clears q, fill count, match count, miss count and err_count to 0, deasserts locked/bit_err/stuck, and sets state to SEARCH. Reset wins over in_valid in the same cycle and is valid mid-lock.
- Prediction: p = q[X1] XNOR q[X2]. q[0] is the newest bit; each accepted bit shifts q[i+1]<=q[i].
- Bits are accepted only on edges with in_valid=1. When in_valid=0, all state holds and bit_err=0.
- All outputs are registered: each reflects the bit accepted at the previous edge (latency 1).
- SEARCH:
  - q[0] <= in, so the register is filled from the received stream.
  - A fill counter saturates at WIDTH. Until it reaches WIDTH, no comparison is made.
  - Once full: if in==p, match count +1; otherwise match count is set to 0.
  - When an edge brings match count to LOCK_COUNT and the post-shift q is not all ones, go to LOCKED and set locked=1 at that edge. With the default parameters this happens on the 26th accepted clean bit.
  - If q is all ones while full, match count is held at 0 and stuck is set to 1.
  - bit_err is never asserted and err_count never changes in SEARCH.
- LOCKED (flywheel):
  - q[0] <= p, never in, so line errors do not propagate.
  - in!=p: bit_err=1, err_count +1 (saturating at 2^ERR_W-1), miss count +1.
  - in==p: miss count is set to 0.
  - When miss count reaches LOSS_THRESH, go to SEARCH. On that transition, locked=0 and the fill, match and miss counts clear. err_count is kept.
  - If q becomes all ones, set stuck=1 and go to SEARCH. This is unreachable from a legal stream.
- Simultaneous events:
  - If a mismatch reaches LOSS_THRESH, that bit still pulses bit_err and still increments err_count.
  - Mismatch and all-ones on the same edge: the all-ones rule takes precedence for the state transition.
- Width rules:
  - fill count is $clog2(WIDTH+1) bits.
  - match and miss counters are $clog2(max(LOCK_COUNT, LOSS_THRESH)+1) bits.
  - No counter wraps.

Decomposition:
- Package lfsr_pkg holds:
  - state enum chk_state_t {SEARCH, LOCKED};
  - default constants LFSR_WIDTH=10, LFSR_X1=6, LFSR_X2=9, shared with the generator.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output count), is instantiated for err_count and the match/miss counters.
- The FSM and the prediction shift register stay in lfsr_checker.

Test Plan:
- Loopback generator (seed 0101010101) -> checker, in_valid=1, 300 bits: locked rises after the 26th accepted bit; bit_err never pulses; err_count=0; stuck=0.
- Same setup, invert the stream bit at accepted index 150: exactly one bit_err pulse, one cycle after that bit; err_count=1; locked stays 1; following bits match, because q was fed with the prediction.
- Invert indices 200-203, 4 consecutive bits: 4 bit_err pulses; err_count=4; locked=0 the cycle after bit 203; relock after 26 further clean bits; err_count still 4.
- Toggle in_valid pseudo-randomly at 50% duty over 600 cycles: lock timing counted in accepted bits only (26); no errors; outputs hold during in_valid=0.
- Constant in=1 with in_valid=1 for 40 cycles: never locks; stuck=1 after the 10th bit; err_count=0.
- Pull reset_n low for one edge while locked, with in_valid=1: next cycle locked=0, err_count=0, stuck=0, q=0; relock after 26 clean bits.
